// File: rtl/regfile_write_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : regfile_write_scheduler_if                                        |
// | Purpose : Writeback request, reservation, hazard and register-file write    |
// |           bundle between the writeback sources and regfile_write_scheduler. |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
interface regfile_write_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic [ADDR_W-1:0]         RA;
  logic [ADDR_W-1:0]         RB;
  logic                      hazard_a;
  logic                      hazard_b;
  logic [ADDR_W-1:0]         RW;
  logic [DATA_W-1:0]         BusW;
  logic                      WriteEnable;
  logic [ADDR_W:0]           pending_cnt;

  modport master (
    output req, req_addr, req_data, rsv_valid, rsv_addr, RA, RB,
    input  ack, hazard_a, hazard_b, RW, BusW, WriteEnable, pending_cnt
  );

  modport slave (
    input  req, req_addr, req_data, rsv_valid, rsv_addr, RA, RB,
    output ack, hazard_a, hazard_b, RW, BusW, WriteEnable, pending_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : regfile_write_scheduler                                           |
// | Purpose : Round-robin share of the register-file write port plus a         |
// |           per-register pending scoreboard for read-hazard stalls.           |
// | Option  : REGFILE_ZERO_PROTECT_EN makes R0 unwritable and never pending.    |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module regfile_write_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  wire logic                clock,
  input  wire logic                reset_n,
  regfile_write_scheduler_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ADDR_W-1:0]  rw_q, rw_d;
  logic [DATA_W-1:0]  busw_q, busw_d;
  logic               we_q, we_d;
  logic [NREG-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] elig;
  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic               rsv_eff;

  // A requester whose ack is currently high is masked so it cannot be written twice.
  assign elig = bus.req & ~ack_q;

  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_valid && elig[idx]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign win_addr = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_data = bus.req_data[win_idx*DATA_W +: DATA_W];

  always_comb begin
    ack_d    = '0;
    we_d     = 1'b0;
    rw_d     = rw_q;
    busw_d   = busw_q;
    rr_ptr_d = rr_ptr_q;
    if (win_valid) begin
      ack_d[win_idx] = 1'b1;
      rw_d           = win_addr;
      busw_d         = win_data;
      rr_ptr_d       = win_idx;
`ifdef REGFILE_ZERO_PROTECT_EN
      we_d           = (win_addr != '0);
`else
      we_d           = 1'b1;
`endif
    end
  end

`ifdef REGFILE_ZERO_PROTECT_EN
  assign rsv_eff      = bus.rsv_valid && (bus.rsv_addr != '0);
  assign bus.hazard_a = pending_q[bus.RA] && (bus.RA != '0);
  assign bus.hazard_b = pending_q[bus.RB] && (bus.RB != '0);
`else
  assign rsv_eff      = bus.rsv_valid;
  assign bus.hazard_a = pending_q[bus.RA];
  assign bus.hazard_b = pending_q[bus.RB];
`endif

  // Set after clear: a reservation at the commit edge supersedes the landing write.
  always_comb begin
    pending_d = pending_q;
    if (we_q) pending_d[rw_q] = 1'b0;
    if (rsv_eff) pending_d[bus.rsv_addr] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CNT_W'(pending_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack_q     <= '0;
      rw_q      <= '0;
      busw_q    <= '0;
      we_q      <= 1'b0;
      pending_q <= '0;
      cnt_q     <= '0;
      rr_ptr_q  <= PTR_RST;
    end else begin
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      busw_q    <= busw_d;
      we_q      <= we_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.RW          = rw_q;
  assign bus.BusW        = busw_q;
  assign bus.WriteEnable = we_q;
  assign bus.pending_cnt = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_regfile_write_scheduler                                        |
// | Purpose : Directed self-checking bench with a behavioural register file.   |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_regfile_write_scheduler;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  logic [DATA_W-1:0] rf [32] = '{default: '0};
  logic [DATA_W-1:0] busa;

  regfile_write_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (bus.WriteEnable) rf[bus.RW] <= bus.BusW;
  assign busa = rf[bus.RA];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.req[i]                     = r;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic reserve(input logic [ADDR_W-1:0] a);
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = a;
    tick();
    bus.rsv_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h1111_0001);
    set_req(1, 1'b1, 5'd2, 32'h2222_0002);
    set_req(2, 1'b1, 5'd3, 32'h3333_0003);
    tick();
    tick();
    checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL rst_ack: got %b want 000", bus.ack); end
    checks++; if (bus.WriteEnable !== 1'b0) begin failures++; $display("FAIL rst_we: got %b want 0", bus.WriteEnable); end
    checks++; if (bus.pending_cnt !== 6'd0) begin failures++; $display("FAIL rst_cnt: got %0d want 0", bus.pending_cnt); end
    checks++; if (bus.RW !== 5'd0 || bus.BusW !== 32'h0) begin failures++; $display("FAIL rst_rw: got %0d/%h want 0/0", bus.RW, bus.BusW); end
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    tick();
    checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL rr_ack0: got %b want 001", bus.ack); end
    checks++; if (bus.WriteEnable !== 1'b1 || bus.RW !== 5'd1 || bus.BusW !== 32'h1111_0001) begin
      failures++; $display("FAIL rr_w0: got we=%b rw=%0d d=%h want 1/1/11110001", bus.WriteEnable, bus.RW, bus.BusW); end
    set_req(0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (bus.ack !== 3'b010 || bus.RW !== 5'd2 || bus.BusW !== 32'h2222_0002) begin
      failures++; $display("FAIL rr_w1: got ack=%b rw=%0d d=%h want 010/2/22220002", bus.ack, bus.RW, bus.BusW); end
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (bus.ack !== 3'b100 || bus.RW !== 5'd3 || bus.BusW !== 32'h3333_0003) begin
      failures++; $display("FAIL rr_w2: got ack=%b rw=%0d d=%h want 100/3/33330003", bus.ack, bus.RW, bus.BusW); end
    set_req(2, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (bus.WriteEnable !== 1'b0 || bus.ack !== 3'b000) begin
      failures++; $display("FAIL rr_idle: got we=%b ack=%b want 0/000", bus.WriteEnable, bus.ack); end
    bus.RA = 5'd1; #1;
    checks++; if (busa !== 32'h1111_0001) begin failures++; $display("FAIL rr_rd1: got %h want 11110001", busa); end
    bus.RA = 5'd2; #1;
    checks++; if (busa !== 32'h2222_0002) begin failures++; $display("FAIL rr_rd2: got %h want 22220002", busa); end
    bus.RA = 5'd3; #1;
    checks++; if (busa !== 32'h3333_0003) begin failures++; $display("FAIL rr_rd3: got %h want 33330003", busa); end
  endtask

  task automatic test_ack_gating();
    logic [2:0] we_seq;
    int writes;
    writes = 0;
    set_req(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      tick();
      we_seq[c] = bus.WriteEnable;
      if (bus.WriteEnable === 1'b1) writes++;
    end
    set_req(1, 1'b0, 5'd0, 32'h0);
    checks++; if (we_seq !== 3'b101) begin failures++; $display("FAIL gate_seq: got %b want 101 (cycle0 in lsb)", we_seq); end
    checks++; if (writes !== 2) begin failures++; $display("FAIL gate_writes: got %0d want 2", writes); end
    tick();
    checks++; if (bus.WriteEnable !== 1'b0) begin failures++; $display("FAIL gate_idle: got %b want 0", bus.WriteEnable); end
    bus.RA = 5'd7; #1;
    checks++; if (busa !== 32'hDEAD_BEEF) begin failures++; $display("FAIL gate_rd: got %h want deadbeef", busa); end
  endtask

  task automatic test_scoreboard();
    reserve(5'd5);
    bus.RA = 5'd5; bus.RB = 5'd5; #1;
    checks++; if (bus.hazard_a !== 1'b1 || bus.hazard_b !== 1'b1) begin
      failures++; $display("FAIL sb_haz: got a=%b b=%b want 1/1", bus.hazard_a, bus.hazard_b); end
    checks++; if (bus.pending_cnt !== 6'd1) begin failures++; $display("FAIL sb_cnt1: got %0d want 1", bus.pending_cnt); end
    set_req(2, 1'b1, 5'd5, 32'h0000_1234);
    tick();
    checks++; if (bus.WriteEnable !== 1'b1 || bus.RW !== 5'd5 || bus.ack !== 3'b100) begin
      failures++; $display("FAIL sb_grant: got we=%b rw=%0d ack=%b want 1/5/100", bus.WriteEnable, bus.RW, bus.ack); end
    checks++; if (bus.hazard_a !== 1'b1) begin failures++; $display("FAIL sb_nobypass: got %b want 1", bus.hazard_a); end
    set_req(2, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (bus.hazard_a !== 1'b0) begin failures++; $display("FAIL sb_clr: got %b want 0", bus.hazard_a); end
    checks++; if (busa !== 32'h0000_1234) begin failures++; $display("FAIL sb_rd: got %h want 00001234", busa); end
    checks++; if (bus.pending_cnt !== 6'd0) begin failures++; $display("FAIL sb_cnt0: got %0d want 0", bus.pending_cnt); end
    bus.RB = 5'd6; #1;
    checks++; if (bus.hazard_b !== 1'b0) begin failures++; $display("FAIL sb_hazb: got %b want 0", bus.hazard_b); end
  endtask

  task automatic test_simultaneous();
    reserve(5'd9);
    checks++; if (bus.pending_cnt !== 6'd1) begin failures++; $display("FAIL sim_cnt_a: got %0d want 1", bus.pending_cnt); end
    set_req(0, 1'b1, 5'd9, 32'h0000_0099);
    tick();
    checks++; if (bus.WriteEnable !== 1'b1 || bus.RW !== 5'd9) begin
      failures++; $display("FAIL sim_grant: got we=%b rw=%0d want 1/9", bus.WriteEnable, bus.RW); end
    set_req(0, 1'b0, 5'd0, 32'h0);
    reserve(5'd9);
    bus.RA = 5'd9; #1;
    checks++; if (bus.hazard_a !== 1'b1) begin failures++; $display("FAIL sim_setwins: got %b want 1", bus.hazard_a); end
    checks++; if (bus.pending_cnt !== 6'd1) begin failures++; $display("FAIL sim_cnt_b: got %0d want 1", bus.pending_cnt); end
    reserve(5'd9);
    checks++; if (bus.pending_cnt !== 6'd1) begin failures++; $display("FAIL sim_rersv: got %0d want 1", bus.pending_cnt); end
    set_req(1, 1'b1, 5'd12, 32'h0000_0C0C);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (bus.pending_cnt !== 6'd1 || bus.hazard_a !== 1'b1) begin
      failures++; $display("FAIL sim_nonpend: got cnt=%0d haz=%b want 1/1", bus.pending_cnt, bus.hazard_a); end
  endtask

  task automatic test_zero();
    logic             exp_we;
    logic [DATA_W-1:0] exp_r0;
    logic [5:0]       exp_cnt;
    logic             exp_haz;
`ifdef REGFILE_ZERO_PROTECT_EN
    exp_we = 1'b0; exp_r0 = 32'h0; exp_cnt = 6'd1; exp_haz = 1'b0;
`else
    exp_we = 1'b1; exp_r0 = 32'hFFFF_FFFF; exp_cnt = 6'd2; exp_haz = 1'b1;
`endif
    reserve(5'd0);
    bus.RA = 5'd0; #1;
    checks++; if (bus.pending_cnt !== exp_cnt) begin failures++; $display("FAIL zero_rsv_cnt: got %0d want %0d", bus.pending_cnt, exp_cnt); end
    checks++; if (bus.hazard_a !== exp_haz) begin failures++; $display("FAIL zero_haz: got %b want %b", bus.hazard_a, exp_haz); end
    set_req(2, 1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    checks++; if (bus.ack !== 3'b100) begin failures++; $display("FAIL zero_ack: got %b want 100", bus.ack); end
    checks++; if (bus.WriteEnable !== exp_we) begin failures++; $display("FAIL zero_we: got %b want %b", bus.WriteEnable, exp_we); end
    set_req(2, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (busa !== exp_r0) begin failures++; $display("FAIL zero_r0: got %h want %h", busa, exp_r0); end
    checks++; if (bus.pending_cnt !== 6'd1 || bus.hazard_a !== 1'b0) begin
      failures++; $display("FAIL zero_after: got cnt=%0d haz=%b want 1/0", bus.pending_cnt, bus.hazard_a); end
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b1, 5'd3, 32'h5555_5555);
    tick();
    checks++; if (bus.WriteEnable !== 1'b1 || bus.ack !== 3'b001) begin
      failures++; $display("FAIL mid_grant: got we=%b ack=%b want 1/001", bus.WriteEnable, bus.ack); end
    set_req(0, 1'b0, 5'd0, 32'h0);
    reset_n = 1'b0;
    tick();
    checks++; if (bus.WriteEnable !== 1'b0 || bus.ack !== 3'b000) begin
      failures++; $display("FAIL mid_drop: got we=%b ack=%b want 0/000", bus.WriteEnable, bus.ack); end
    checks++; if (bus.pending_cnt !== 6'd0 || bus.RW !== 5'd0) begin
      failures++; $display("FAIL mid_clr: got cnt=%0d rw=%0d want 0/0", bus.pending_cnt, bus.RW); end
    reset_n = 1'b1;
    set_req(1, 1'b1, 5'd4, 32'h4444_4444);
    set_req(0, 1'b1, 5'd8, 32'h8888_8888);
    tick();
    checks++; if (bus.ack !== 3'b001 || bus.RW !== 5'd8) begin
      failures++; $display("FAIL mid_first: got ack=%b rw=%0d want 001/8", bus.ack, bus.RW); end
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    bus.RA        = '0;
    bus.RB        = '0;
    test_reset();
    test_round_robin();
    test_ack_gating();
    test_scoreboard();
    test_simultaneous();
    test_zero();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
